// File: rtl/state_reduce_poly_reduce_ctrl_if.sv
// state_reduce_poly_reduce_ctrl_if: control, RAM and Barrett-reducer signals of the poly-reduce sequencer
interface state_reduce_poly_reduce_ctrl_if #(
  parameter int ADDR_WIDTH     = 9,
  parameter int i_Coeffs_Width = 16,
  parameter int o_Coeffs_Width = 12
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [i_Coeffs_Width-1:0] rd_data;
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [i_Coeffs_Width-1:0] wr_data;
  logic                      brr_enable;
  logic [i_Coeffs_Width-1:0] brr_coeff;
  logic                      brr_done;
  logic [o_Coeffs_Width-1:0] brr_result;
  modport master (
    input  start, rd_data, brr_done, brr_result,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, brr_enable, brr_coeff
  );
  modport slave (
    output start, rd_data, brr_done, brr_result,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, brr_enable, brr_coeff
  );
endinterface

// File: rtl/state_reduce_poly_reduce_ctrl.sv
// state_reduce_poly_reduce_ctrl: walks every coefficient, reduces it through the Barrett unit and writes it back in place
module state_reduce_poly_reduce_ctrl #(
  parameter int KYBER_K        = 2,
  parameter int KYBER_N        = 256,
  parameter int KYBER_Q        = 3329,
  parameter int ADDR_WIDTH     = 9,
  parameter int i_Coeffs_Width = 16,
  parameter int o_Coeffs_Width = 12,
  parameter int CSUBQ          = 1
) (
  input logic clk,
  input logic reset_n,
  state_reduce_poly_reduce_ctrl_if.master bus
);
  localparam int M = KYBER_K * KYBER_N;
  typedef enum logic [2:0] {IDLE, READ, LATCH, ISSUE, WAIT, WRITE, FIN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0]     idx;
  logic [i_Coeffs_Width-1:0] coeff_reg;
  logic [o_Coeffs_Width-1:0] res_reg;
  logic [o_Coeffs_Width-1:0] res_csub;
  logic                      last;
  logic                      sub;
  assign last     = idx == ADDR_WIDTH'(M - 1);
  assign sub      = (CSUBQ != 0) && ({1'b0, res_reg} >= (o_Coeffs_Width + 1)'(KYBER_Q));
  assign res_csub = sub ? res_reg - o_Coeffs_Width'(KYBER_Q) : res_reg;
  // State register; reset abandons any coefficient in flight
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // Next state: fixed read/latch/issue walk, WAIT holds for the reducer, WRITE loops or finishes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? READ : IDLE;
      READ:    state_nx = LATCH;
      LATCH:   state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = bus.brr_done ? WRITE : WAIT;
      WRITE:   state_nx = last ? FIN : READ;
      default: state_nx = IDLE;
    endcase
  end
  // Index, operand and result registers; operand is held until the next LATCH so the reducer can re-read it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx       <= '0;
      coeff_reg <= '0;
      res_reg   <= '0;
    end else begin
      if (state == IDLE && bus.start) idx <= '0;
      if (state == WRITE && !last) idx <= idx + 1'b1;
      if (state == LATCH) coeff_reg <= bus.rd_data;
      if (state == WAIT && bus.brr_done) res_reg <= bus.brr_result;
    end
  assign bus.busy       = state != IDLE && state != FIN;
  assign bus.done       = state == FIN;
  assign bus.rd_en      = state == READ;
  assign bus.rd_addr    = idx;
  assign bus.wr_en      = state == WRITE;
  assign bus.wr_addr    = idx;
  assign bus.wr_data    = i_Coeffs_Width'(res_csub);
  assign bus.brr_enable = state == ISSUE;
  assign bus.brr_coeff  = coeff_reg;
endmodule

// File: tb/tb_state_reduce_poly_reduce_ctrl.sv
// tb_state_reduce_poly_reduce_ctrl: directed bench with RAM and Barrett reducer models
module tb_state_reduce_poly_reduce_ctrl;
  localparam int M = 512;
  logic clk = 0;
  logic reset_n = 0;
  always #5 clk = ~clk;
  state_reduce_poly_reduce_ctrl_if #(.ADDR_WIDTH(9), .i_Coeffs_Width(16), .o_Coeffs_Width(12)) bus ();
  state_reduce_poly_reduce_ctrl_if #(.ADDR_WIDTH(9), .i_Coeffs_Width(16), .o_Coeffs_Width(12)) bus_n ();
  state_reduce_poly_reduce_ctrl #(.CSUBQ(1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  state_reduce_poly_reduce_ctrl #(.CSUBQ(0)) dut_n (.clk(clk), .reset_n(reset_n), .bus(bus_n));
  assign bus_n.start      = bus.start;
  assign bus_n.rd_data    = bus.rd_data;
  assign bus_n.brr_done   = bus.brr_done;
  assign bus_n.brr_result = bus.brr_result;
  int checks = 0, failures = 0, cyc = 0, cnt = 0, delay = 5, s = 0;
  logic stub = 0, spur_en = 0, hammer = 0, chk_n = 0, clr = 0;
  logic [11:0] stub_val = 0, exp_n = 0;
  logic [15:0] mem [M];
  logic [15:0] hold = 0;
  int wr_cnt, order_err, first_wr, done_cnt, done_cyc, bsy_cnt, busy_first, busy_last, stab_err, n_err, w5;
  function automatic logic [11:0] red(input logic [15:0] a);
    int r;
    r = int'($signed(a)) % 3329;
    if (r < 0) r += 3329;
    return 12'(r);
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end
  always @(posedge clk)
    if (!reset_n) cnt <= 0;
    else if (bus.brr_enable) cnt <= delay;
    else if (cnt != 0) cnt <= cnt - 1;
  assign bus.brr_done   = (cnt == 1) || (spur_en && bus.rd_en);
  assign bus.brr_result = stub ? stub_val : red(bus.brr_coeff);
  always @(negedge clk) begin
    if (clr) begin
      wr_cnt = 0; order_err = 0; first_wr = 0; done_cnt = 0; done_cyc = 0;
      bsy_cnt = 0; busy_first = 0; busy_last = 0; stab_err = 0; n_err = 0; w5 = 0;
    end
    if (reset_n) begin
      if (bus.wr_en) begin
        if (wr_cnt == 0) first_wr = cyc;
        if (int'(bus.wr_addr) != wr_cnt) order_err++;
        if (bus.wr_addr == 9'd5) w5++;
        if (chk_n && (bus_n.wr_data !== {4'b0, exp_n} || !bus_n.wr_en)) n_err++;
        wr_cnt++;
      end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.busy) begin
        if (bsy_cnt == 0) busy_first = cyc;
        busy_last = cyc;
        bsy_cnt++;
      end
      if (bus.brr_enable) hold = bus.brr_coeff;
      else if (cnt != 0 && bus.brr_coeff !== hold) stab_err++;
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic launch;
    clr = 1;
    bus.start = 1;
    s = cyc;
    tick;
    clr = 0;
    bus.start = 0;
  endtask
  task automatic finish(input int per, input string tag);
    int k = 0;
    while (done_cnt == 0 && k < per * M + 50) begin
      tick;
      k++;
      bus.start = hammer && bus.busy && cyc[0];
    end
    bus.start = 0;
    chk({tag, "_done_cyc"}, done_cyc, s + per * M + 1);
    chk({tag, "_wr_cnt"}, wr_cnt, M);
    chk({tag, "_wr_order"}, order_err, 0);
    chk({tag, "_first_wr"}, first_wr, s + per);
    chk({tag, "_busy_cycles"}, bsy_cnt, per * M);
    chk({tag, "_busy_first"}, busy_first, s + 1);
    chk({tag, "_busy_last"}, busy_last, s + per * M);
    chk({tag, "_coeff_stable"}, stab_err, 0);
    chk({tag, "_nosub_data"}, n_err, 0);
    tick;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_pulse"}, int'(bus.done), 0);
    chk({tag, "_busy_after"}, int'(bus.busy), 0);
  endtask
  initial begin
    int bad, k;
    bus.start = 0;
    for (int i = 0; i < M; i++) mem[i] = 16'hAAAA;
    repeat (3) tick;
    chk("reset_outputs", int'(|{bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.brr_enable,
        bus.rd_addr, bus.wr_addr, bus.wr_data, bus.brr_coeff}), 0);
    reset_n = 1;
    tick;
    chk("idle_busy", int'(bus.busy), 0);
    for (int i = 0; i < M; i++) mem[i] = 16'd0;
    mem[0] = 16'h7FFF; mem[1] = 16'hFFFF; mem[2] = 16'd3329; mem[3] = 16'd3328;
    mem[100] = 16'h8000; mem[511] = 16'd6658;
    launch;
    finish(9, "full");
    chk("mem0", int'(mem[0]), 2806);
    chk("mem1", int'(mem[1]), 3328);
    chk("mem2", int'(mem[2]), 0);
    chk("mem3", int'(mem[3]), 3328);
    chk("mem4", int'(mem[4]), 0);
    chk("mem100", int'(mem[100]), 522);
    chk("mem511", int'(mem[511]), 0);
    stub = 1;
    stub_val = 12'd3329;
    for (int i = 0; i < M; i++) mem[i] = 16'hAAAA;
    mem[4] = 16'd1234;
    mem[5] = 16'd1234;
    launch;
    k = 0;
    while (!(bus.wr_addr == 9'd5 && cnt == 3) && k < 200) begin tick; k++; end
    chk("mid_wait_idx5", int'(bus.wr_addr == 9'd5 && cnt == 3), 1);
    reset_n = 0;
    #1;
    chk("midpass_reset_outputs", int'(|{bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.brr_enable,
        bus.rd_addr, bus.wr_addr, bus.wr_data, bus.brr_coeff}), 0);
    tick;
    tick;
    chk("midpass_mem5_kept", int'(mem[5]), 1234);
    chk("midpass_mem4_written", int'(mem[4]), 0);
    chk("midpass_no_wr5", w5, 0);
    reset_n = 1;
    tick;
    for (int i = 0; i < M; i++) mem[i] = 16'hAAAA;
    chk_n = 1;
    exp_n = 12'd3329;
    launch;
    finish(9, "csubq3329");
    bad = 0;
    for (int i = 0; i < M; i++) if (mem[i] !== 16'd0) bad++;
    chk("csubq3329_mem", bad, 0);
    stub_val = 12'd3328;
    exp_n = 12'd3328;
    hammer = 1;
    launch;
    finish(9, "hammer3328");
    hammer = 0;
    bad = 0;
    for (int i = 0; i < M; i++) if (mem[i] !== 16'd3328) bad++;
    chk("hammer3328_mem", bad, 0);
    launch;
    chk("b2b_busy", int'(bus.busy), 1);
    finish(9, "b2b");
    stub = 0;
    chk_n = 0;
    delay = 20;
    spur_en = 1;
    for (int i = 0; i < M; i++) mem[i] = 16'(i + 3329);
    launch;
    finish(24, "slow");
    bad = 0;
    for (int i = 0; i < M; i++) if (int'(mem[i]) != i) bad++;
    chk("slow_mem", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
